neuron_mac_seq: RTL and testbench

- Parametrised successor to the fixed two-input output neuron.
- Computes a weighted sum of N_INPUTS unsigned fixed-point activations and signed Q1.7 weights, with an optional bias.
- Uses one shared multiplier: one product per cycle, so there are no N parallel multipliers.
- Sits between the hidden layer and the loss calculator; the result is held under a valid/ready handshake until the consumer accepts it.

---
 rtl/nn_pkg.sv | 29 ++
 rtl/mac_unit.sv | 54 +++++
 rtl/neuron_mac_seq.sv | 140 ++++++++++++++
 tb/tb_neuron_mac_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types, default widths and saturation helper for the neuron MAC datapath.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int X_W_DEF   = 10;
    localparam int W_W_DEF   = 8;
    localparam int OUT_W_DEF = 21;

    // Clamp a signed value to the range of a signed word of the given width.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned      width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi)
            sat_signed = hi;
        else if (value < lo)
            sat_signed = lo;
        else
            sat_signed = value;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Single shared multiplier and accumulator: unsigned activation times signed weight,
// accumulated on en_i, loaded with the sign-extended bias on load_i.
module mac_unit
    import nn_pkg::*;
#(
    parameter int X_W   = X_W_DEF,
    parameter int W_W   = W_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int ACC_W = OUT_W_DEF + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [X_W-1:0]   x_i,
    input  logic [W_W-1:0]   w_i,
    input  logic [OUT_W-1:0] bias_i,
    output logic [ACC_W-1:0] acc_o
);

    localparam int P_W = X_W + W_W + 1;

    logic signed [P_W-1:0]   x_ext;
    logic signed [P_W-1:0]   w_ext;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    // Activation is zero-extended, weight sign-extended, so the product is exact in P_W bits.
    assign x_ext = {{(W_W + 1){1'b0}}, x_i};
    assign w_ext = {{(X_W + 1){w_i[W_W-1]}}, w_i};
    assign prod  = x_ext * w_ext;

    always_comb begin
        acc_d = acc_q;
        if (clear_i)
            acc_d = '0;
        else if (load_i)
            acc_d = {{(ACC_W - OUT_W){bias_i[OUT_W-1]}}, bias_i};
        else if (en_i)
            acc_d = acc_q + {{(ACC_W - P_W){prod[P_W-1]}}, prod};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential weighted-sum neuron: one product per cycle, saturated result held under valid/ready.
// Optional build macro NEURON_MAC_RELU_EN clamps negative results to zero after saturation.
module neuron_mac_seq
    import nn_pkg::*;
#(
    parameter int N_INPUTS = 2,
    parameter int X_W      = X_W_DEF,
    parameter int W_W      = W_W_DEF,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [N_INPUTS*X_W-1:0] x_i,
    input  logic [N_INPUTS*W_W-1:0] w_i,
    input  logic [OUT_W-1:0]        bias_i,
    output logic                    busy_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [OUT_W-1:0]        sum_o,
    output logic                    sat_o
);

    localparam int P_W   = X_W + W_W + 1;
    localparam int SUM_W = P_W + $clog2(N_INPUTS) + 1;
    // One extra bit beyond both the product sum and the bias keeps bias + sum from wrapping.
    localparam int ACC_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N_INPUTS*X_W-1:0] x_q, x_d;
    logic [N_INPUTS*W_W-1:0] w_q, w_d;
    logic                    valid_q, valid_d;
    logic [OUT_W-1:0]        sum_q, sum_d;
    logic                    sat_q, sat_d;
    logic                    load, en, clear;
    logic [ACC_W-1:0]        acc;
    logic signed [63:0]      acc_ext;
    logic signed [63:0]      acc_sat;
    logic [OUT_W-1:0]        result;
    logic                    sat_flag;

    mac_unit #(
        .X_W  (X_W),
        .W_W  (W_W),
        .OUT_W(OUT_W),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(clear),
        .load_i (load),
        .en_i   (en),
        .x_i    (x_q[idx_q*X_W +: X_W]),
        .w_i    (w_q[idx_q*W_W +: W_W]),
        .bias_i (bias_i),
        .acc_o  (acc)
    );

    assign acc_ext  = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};
    assign acc_sat  = sat_signed(acc_ext, OUT_W);
    assign sat_flag = (acc_sat != acc_ext);

`ifdef NEURON_MAC_RELU_EN
    assign result = acc_sat[63] ? '0 : acc_sat[OUT_W-1:0];
`else
    assign result = acc_sat[OUT_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        w_d     = w_q;
        valid_d = valid_q;
        sum_d   = sum_q;
        sat_d   = sat_q;
        load    = 1'b0;
        en      = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d     = x_i;
                    w_d     = w_i;
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                en    = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX)
                    state_d = DONE;
            end
            DONE: begin
                // First DONE cycle registers the result; afterwards wait for the consumer.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    sum_d   = result;
                    sat_d   = sat_flag;
                end else if (ready_i) begin
                    valid_d = 1'b0;
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Randomized bench for neuron_mac_seq with a transaction-level reference model.
module tb_neuron_mac_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start[2];
    logic ready[2];
    int   xv[2][4];
    int   wv[2][4];
    int   bias[2];

    logic [19:0] x0;
    logic [15:0] w0;
    logic [20:0] b0;
    logic [20:0] s0;
    logic [39:0] x1;
    logic [31:0] w1;
    logic [11:0] b1;
    logic [11:0] s1;
    logic busy[2];
    logic valid[2];
    logic satv[2];
    int   sumv[2];

    int total = 0;
    int bad = 0;

    always_comb begin
        x0 = '0; w0 = '0; x1 = '0; w1 = '0;
        for (int k = 0; k < 2; k++) begin
            x0[k*10 +: 10] = 10'(xv[0][k]);
            w0[k*8 +: 8]   = 8'(wv[0][k]);
        end
        for (int k = 0; k < 4; k++) begin
            x1[k*10 +: 10] = 10'(xv[1][k]);
            w1[k*8 +: 8]   = 8'(wv[1][k]);
        end
    end
    assign b0 = 21'(bias[0]);
    assign b1 = 12'(bias[1]);
    assign sumv[0] = int'($signed(s0));
    assign sumv[1] = int'($signed(s1));

    neuron_mac_seq #(.N_INPUTS(2), .X_W(10), .W_W(8), .OUT_W(21)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[0]), .x_i(x0), .w_i(w0), .bias_i(b0),
        .busy_o(busy[0]), .valid_o(valid[0]), .ready_i(ready[0]), .sum_o(s0), .sat_o(satv[0]));

    neuron_mac_seq #(.N_INPUTS(4), .X_W(10), .W_W(8), .OUT_W(12)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[1]), .x_i(x1), .w_i(w1), .bias_i(b1),
        .busy_o(busy[1]), .valid_o(valid[1]), .ready_i(ready[1]), .sum_o(s1), .sat_o(satv[1]));

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: the weighted sum in plain 64-bit arithmetic, then clamp and optional ReLU.
    function automatic void model_calc(input int d, output int s, output bit st);
        longint acc, mx, mn;
        int n, ow;
        n  = (d == 0) ? 2 : 4;
        ow = (d == 0) ? 21 : 12;
        acc = longint'(bias[d]);
        for (int k = 0; k < n; k++)
            acc += longint'(xv[d][k]) * longint'(wv[d][k]);
        mx = (longint'(1) <<< (ow - 1)) - 1;
        mn = -mx - 1;
        st = 1'b0;
        if (acc > mx) begin acc = mx; st = 1'b1; end
        else if (acc < mn) begin acc = mn; st = 1'b1; end
`ifdef NEURON_MAC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        s = int'(acc);
    endfunction

    bit m_busy[2], m_valid[2], m_sat[2], m_expsat[2];
    int m_cnt[2], m_sum[2], m_exp[2];

    always @(negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_valid[d] = 0; m_sat[d] = 0; m_sum[d] = 0; m_cnt[d] = 0;
        end
    end

    // Transaction timing: result appears N+1 edges after the accepted start.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d] = 0; m_valid[d] = 0; m_sat[d] = 0; m_sum[d] = 0; m_cnt[d] = 0;
            end else if (m_valid[d] && ready[d]) begin
                m_valid[d] = 0;
                m_busy[d]  = 0;
            end else if (m_busy[d]) begin
                m_cnt[d]++;
                if (m_cnt[d] == ((d == 0) ? 3 : 5)) begin
                    m_valid[d] = 1;
                    m_sum[d]   = m_exp[d];
                    m_sat[d]   = m_expsat[d];
                end
            end else if (start[d]) begin
                m_busy[d] = 1;
                m_cnt[d]  = 0;
                model_calc(d, m_exp[d], m_expsat[d]);
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", d), int'(busy[d]), int'(m_busy[d]));
            chk($sformatf("valid%0d", d), int'(valid[d]), int'(m_valid[d]));
            chk($sformatf("sum%0d", d), sumv[d], m_sum[d]);
            chk($sformatf("sat%0d", d), int'(satv[d]), int'(m_sat[d]));
        end
    end

    task automatic run(input int d, output int n);
        start[d] = 1;
        @(posedge clk); #1;
        start[d] = 0;
        n = 0;
        while (!valid[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!valid[d]) chk("valid_timeout", 0, 1);
    endtask

    task automatic accept(input int d);
        ready[d] = 1;
        @(posedge clk); #1;
        ready[d] = 0;
        chk("accept_valid", int'(valid[d]), 0);
        chk("accept_busy", int'(busy[d]), 0);
    endtask

    task automatic set0(input int xa, xb, wa, wb, b);
        xv[0][0] = xa; xv[0][1] = xb; wv[0][0] = wa; wv[0][1] = wb; bias[0] = b;
    endtask

    task automatic set1(input int xa, xb, xc, xd, wa, wb, wc, wd, b);
        xv[1][0] = xa; xv[1][1] = xb; xv[1][2] = xc; xv[1][3] = xd;
        wv[1][0] = wa; wv[1][1] = wb; wv[1][2] = wc; wv[1][3] = wd; bias[1] = b;
    endtask

    initial begin
        int n;
        int relu_exp;
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; ready[d] = 0; bias[d] = 0;
            for (int k = 0; k < 4; k++) begin xv[d][k] = 0; wv[d][k] = 0; end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sum", sumv[0], 0);
        chk("reset_valid", int'(valid[0]), 0);
        rst_n = 1;

        set0(100, 200, 64, 32, 0);
        run(0, n);
        chk("lat_n2", n, 3);
        chk("sum_basic", sumv[0], 12800);
        chk("sat_basic", int'(satv[0]), 0);
        accept(0);

`ifdef NEURON_MAC_RELU_EN
        relu_exp = 0;
`else
        relu_exp = -261893;
`endif
        set0(1023, 1023, -128, -128, -5);
        run(0, n);
        chk("sum_neg", sumv[0], relu_exp);
        chk("sat_neg", int'(satv[0]), 0);
        accept(0);

        set1(1023, 1023, 0, 0, 127, 127, 0, 0, 0);
        run(1, n);
        chk("lat_n4", n, 5);
        chk("sum_clamp", sumv[1], 2047);
        chk("sat_clamp", int'(satv[1]), 1);
        accept(1);

        set0(3, 4, 10, 20, 7);
        run(0, n);
        for (int i = 0; i < 10; i++) begin
            start[0] = ~start[0];
            set0(i + 50, i, 5, -9, i);
            @(posedge clk); #1;
            chk("hold_valid", int'(valid[0]), 1);
            chk("hold_sum", sumv[0], 117);
        end
        start[0] = 1;
        ready[0] = 1;
        @(posedge clk); #1;
        ready[0] = 0;
        start[0] = 0;
        chk("coincident_start_busy", int'(busy[0]), 0);
        chk("release_valid", int'(valid[0]), 0);

        set0(900, 900, 100, 100, 1000);
        start[0] = 1;
        @(posedge clk); #1;
        start[0] = 0;
        rst_n = 0;
        #1;
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_sum", sumv[0], 0);
        @(posedge clk); #1;
        rst_n = 1;
        set0(5, 7, 1, 1, 0);
        run(0, n);
        chk("after_abort_sum", sumv[0], 12);
        chk("after_abort_lat", n, 3);
        accept(0);

        set1(1, 2, 3, 4, 1, 1, 1, 1, 0);
        ready[1] = 1;
        run(1, n);
        chk("b2b_first", sumv[1], 10);
        set1(10, 10, 10, 10, 2, -1, 3, 0, -1);
        start[1] = 1;
        @(posedge clk); #1;
        chk("b2b_start_ignored", int'(busy[1]), 0);
        run(1, n);
        chk("b2b_lat", n, 5);
        chk("b2b_second", sumv[1], 39);
        @(posedge clk); #1;
        ready[1] = 0;

        for (int c = 0; c < 800; c++) begin
            for (int d = 0; d < 2; d++) begin
                start[d] = ($urandom % 4) == 0;
                ready[d] = ($urandom % 2) == 1;
                for (int k = 0; k < 4; k++) begin
                    xv[d][k] = int'($urandom_range(0, 1023));
                    wv[d][k] = int'($urandom_range(0, 255)) - 128;
                end
            end
            bias[0] = int'($urandom_range(0, 2097151)) - 1048576;
            bias[1] = int'($urandom_range(0, 4095)) - 2048;
            @(posedge clk); #1;
        end
        start[0] = 0; start[1] = 0;
        ready[0] = 1; ready[1] = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_busy0", int'(busy[0]), 0);
        chk("drain_busy1", int'(busy[1]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
